// File: rtl/serial_unremap_pkg.sv
// Shared constants, read-state encoding and the split-to-natural address map
// for the serial even/odd un-remapper.
package serial_unremap_pkg;

   localparam int NB_DEF    = 16;
   localparam int N_DEF     = 8;
   localparam int LOG2N_DEF = 3;

   typedef enum logic {
      RD_IDLE  = 1'b0,
      RD_DRAIN = 1'b1
   } rd_state_e;

   // Natural index k lives at split position k/2 (even k) or n/2 + k/2 (odd k).
   function automatic int unremap_addr(input int k, input int n);
      if (k[0] == 1'b0) begin
         return k >> 32'd1;
      end else begin
         return (n >> 32'd1) + (k >> 32'd1);
      end
   endfunction

endpackage

// File: rtl/serial_unremap_pingpong_buf.sv
// Two-bank sample store: one synchronous write port, one asynchronous read port,
// each addressed by bank select plus index within the bank.
module pingpong_buf #(
   parameter int NB    = 16,
   parameter int N     = 8,
   parameter int LOG2N = 3
) (
   input  logic             clk,
   input  logic             we,
   input  logic             wr_bank,
   input  logic [LOG2N-1:0] wr_idx,
   input  logic [NB-1:0]    wr_data,
   input  logic             rd_bank,
   input  logic [LOG2N-1:0] rd_idx,
   output logic [NB-1:0]    rd_data
);

   logic [NB-1:0] mem_q [0:2*N-1];

   // Storage is deliberately unreset; the full[] interlock keeps stale words from being read.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[{wr_bank, wr_idx}] <= wr_data;
      end
   end

   assign rd_data = mem_q[{rd_bank, rd_idx}];

endmodule

// File: rtl/serial_unremap.sv
// Inverse even/odd commutator: collects a split-order frame into one bank of a
// ping-pong buffer while the other bank is replayed in natural order.
module serial_unremap
   import serial_unremap_pkg::*;
#(
   parameter int NB    = NB_DEF,
   parameter int N     = N_DEF,
   parameter int LOG2N = LOG2N_DEF
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          start,
   input  logic          valid_in,
   input  logic [NB-1:0] input_data,
   output logic          valid_out,
   output logic [NB-1:0] output_data,
   output logic          frame_first,
   output logic          overflow
);

   localparam logic [LOG2N-1:0] CNT_LAST = LOG2N'(N - 1);

   logic [LOG2N-1:0] wr_cnt_q, wr_cnt_d;
   logic             wr_bank_q, wr_bank_d;
   logic [LOG2N-1:0] rd_cnt_q, rd_cnt_d;
   logic             rd_bank_q, rd_bank_d;
   logic [1:0]       full_q, full_d;
   logic             overflow_q, overflow_d;
   logic             valid_out_q, valid_out_d;
   logic [NB-1:0]    output_data_q, output_data_d;
   logic             frame_first_q, frame_first_d;

   logic             buf_we_s;
   logic             buf_wr_bank_s;
   logic [LOG2N-1:0] buf_wr_idx_s;
   logic [LOG2N-1:0] rd_addr_s;
   logic [NB-1:0]    rd_data_s;
   rd_state_e        rd_state_s;

   pingpong_buf #(
      .NB    (NB),
      .N     (N),
      .LOG2N (LOG2N)
   ) u_buf (
      .clk     (clk),
      .we      (buf_we_s),
      .wr_bank (buf_wr_bank_s),
      .wr_idx  (buf_wr_idx_s),
      .wr_data (input_data),
      .rd_bank (rd_bank_q),
      .rd_idx  (rd_addr_s),
      .rd_data (rd_data_s)
   );

   // Next-state for counters, bank flags and output registers; start overrides everything.
   always_comb begin
      wr_cnt_d      = wr_cnt_q;
      wr_bank_d     = wr_bank_q;
      rd_cnt_d      = rd_cnt_q;
      rd_bank_d     = rd_bank_q;
      full_d        = full_q;
      overflow_d    = overflow_q;
      valid_out_d   = 1'b0;
      output_data_d = output_data_q;
      frame_first_d = 1'b0;
      buf_we_s      = 1'b0;
      buf_wr_bank_s = wr_bank_q;
      buf_wr_idx_s  = wr_cnt_q;
      rd_state_s    = full_q[rd_bank_q] ? RD_DRAIN : RD_IDLE;
      rd_addr_s     = LOG2N'(unremap_addr(int'(rd_cnt_q), N));

      if (start) begin
         wr_bank_d     = 1'b0;
         rd_cnt_d      = '0;
         rd_bank_d     = 1'b0;
         full_d        = 2'b00;
         overflow_d    = 1'b0;
         buf_wr_bank_s = 1'b0;
         buf_wr_idx_s  = '0;
         if (valid_in) begin
            buf_we_s = 1'b1;
            wr_cnt_d = LOG2N'(1);
         end else begin
            wr_cnt_d = '0;
         end
      end else begin
         case (rd_state_s)
            RD_DRAIN: begin
               output_data_d = rd_data_s;
               valid_out_d   = 1'b1;
               frame_first_d = (rd_cnt_q == '0);
               if (rd_cnt_q == CNT_LAST) begin
                  full_d[rd_bank_q] = 1'b0;
                  rd_bank_d         = ~rd_bank_q;
                  rd_cnt_d          = '0;
               end else begin
                  rd_cnt_d = rd_cnt_q + LOG2N'(1);
               end
            end
            RD_IDLE: begin
               valid_out_d = 1'b0;
            end
            default: begin
               valid_out_d = 1'b0;
            end
         endcase

         // Write side runs after the read release so a same-cycle set of full[] wins.
         if (valid_in) begin
            if (full_q[wr_bank_q]) begin
               overflow_d = 1'b1;
            end else begin
               buf_we_s = 1'b1;
               if (wr_cnt_q == CNT_LAST) begin
                  full_d[wr_bank_q] = 1'b1;
                  wr_bank_d         = ~wr_bank_q;
                  wr_cnt_d          = '0;
               end else begin
                  wr_cnt_d = wr_cnt_q + LOG2N'(1);
               end
            end
         end else begin
            wr_cnt_d = wr_cnt_q;
         end
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_cnt_q      <= '0;
         wr_bank_q     <= 1'b0;
         rd_cnt_q      <= '0;
         rd_bank_q     <= 1'b0;
         full_q        <= 2'b00;
         overflow_q    <= 1'b0;
         valid_out_q   <= 1'b0;
         output_data_q <= '0;
         frame_first_q <= 1'b0;
      end else begin
         wr_cnt_q      <= wr_cnt_d;
         wr_bank_q     <= wr_bank_d;
         rd_cnt_q      <= rd_cnt_d;
         rd_bank_q     <= rd_bank_d;
         full_q        <= full_d;
         overflow_q    <= overflow_d;
         valid_out_q   <= valid_out_d;
         output_data_q <= output_data_d;
         frame_first_q <= frame_first_d;
      end
   end

   assign valid_out   = valid_out_q;
   assign output_data = output_data_q;
   assign frame_first = frame_first_q;
   assign overflow    = overflow_q;

endmodule

// File: tb/tb_serial_unremap.sv
// Directed bench for serial_unremap: split-order frames in, natural order and
// cycle-exact timing checked against hand-derived expectations.
module tb_serial_unremap;

   localparam int NB = 16;
   localparam int N  = 8;

   typedef logic [NB-1:0] frame_t [N];

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic          valid_in = 1'b0;
   logic [NB-1:0] input_data = '0;
   logic          valid_out;
   logic [NB-1:0] output_data;
   logic          frame_first;
   logic          overflow;

   int chk_cnt = 0;
   int pass_cnt = 0;
   int cyc = 0;

   logic [NB-1:0] mq_data [$];
   int            mq_cyc [$];
   logic          mq_first [$];

   serial_unremap #(.NB(NB), .N(N), .LOG2N(3)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .start       (start),
      .valid_in    (valid_in),
      .input_data  (input_data),
      .valid_out   (valid_out),
      .output_data (output_data),
      .frame_first (frame_first),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Record every valid output word with the index of the edge that produced it.
   always @(negedge clk) begin
      if (valid_out === 1'b1) begin
         mq_data.push_back(output_data);
         mq_cyc.push_back(cyc);
         mq_first.push_back(frame_first);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_q();
      mq_data.delete();
      mq_cyc.delete();
      mq_first.delete();
   endtask

   // Model of the upstream remapper: natural frame -> even samples then odd samples.
   task automatic feed_frame(input frame_t nat);
      for (int j = 0; j < N; j++) begin
         if (j < N/2) input_data = nat[2*j];
         else         input_data = nat[2*(j-N/2)+1];
         valid_in = 1'b1;
         tick();
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      tick();
      tick();
      chk_cnt++; if (valid_out !== 1'b0) $display("FAIL reset_valid_out got %b want 0", valid_out); else pass_cnt++;
      chk_cnt++; if (output_data !== 16'h0000) $display("FAIL reset_output_data got %h want 0000", output_data); else pass_cnt++;
      chk_cnt++; if (frame_first !== 1'b0) $display("FAIL reset_frame_first got %b want 0", frame_first); else pass_cnt++;
      chk_cnt++; if (overflow !== 1'b0) $display("FAIL reset_overflow got %b want 0", overflow); else pass_cnt++;
      @(negedge clk);
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_single_frame();
      logic [NB-1:0] sv [N];
      logic [NB-1:0] gd;
      int gc, e0;
      logic gf;
      sv = '{16'd0, 16'd2, 16'd4, 16'd6, 16'd1, 16'd3, 16'd5, 16'd7};
      clear_q();
      e0 = cyc + 1;
      for (int j = 0; j < N; j++) begin
         valid_in = 1'b1; input_data = sv[j]; tick();
      end
      valid_in = 1'b0;
      repeat (N + 4) tick();
      chk_cnt++; if (mq_data.size() != N) $display("FAIL single_count got %0d want %0d", mq_data.size(), N); else pass_cnt++;
      for (int i = 0; i < N; i++) begin
         gd = (i < mq_data.size()) ? mq_data[i] : 'x;
         gc = (i < mq_cyc.size()) ? mq_cyc[i] : -1;
         gf = (i < mq_first.size()) ? mq_first[i] : 1'bx;
         chk_cnt++; if (gd !== NB'(i)) $display("FAIL single_data[%0d] got %h want %h", i, gd, NB'(i)); else pass_cnt++;
         chk_cnt++; if (gc != e0 + N + i) $display("FAIL single_latency[%0d] got cycle %0d want %0d", i, gc, e0 + N + i); else pass_cnt++;
         chk_cnt++; if (gf !== (i == 0)) $display("FAIL single_first[%0d] got %b want %b", i, gf, (i == 0)); else pass_cnt++;
      end
   endtask

   task automatic test_back_to_back();
      frame_t nat;
      logic [NB-1:0] gd;
      int gc, e0;
      logic gf;
      clear_q();
      e0 = cyc + 1;
      for (int f = 0; f < 4; f++) begin
         for (int k = 0; k < N; k++) nat[k] = NB'(f*N + k);
         feed_frame(nat);
      end
      valid_in = 1'b0;
      repeat (N + 4) tick();
      chk_cnt++; if (mq_data.size() != 4*N) $display("FAIL b2b_count got %0d want %0d", mq_data.size(), 4*N); else pass_cnt++;
      for (int i = 0; i < 4*N; i++) begin
         gd = (i < mq_data.size()) ? mq_data[i] : 'x;
         gc = (i < mq_cyc.size()) ? mq_cyc[i] : -1;
         gf = (i < mq_first.size()) ? mq_first[i] : 1'bx;
         chk_cnt++; if (gd !== NB'(i)) $display("FAIL b2b_data[%0d] got %h want %h", i, gd, NB'(i)); else pass_cnt++;
         chk_cnt++; if (gc != e0 + N + i) $display("FAIL b2b_cycle[%0d] got %0d want %0d", i, gc, e0 + N + i); else pass_cnt++;
         chk_cnt++; if (gf !== (i % N == 0)) $display("FAIL b2b_first[%0d] got %b want %b", i, gf, (i % N == 0)); else pass_cnt++;
      end
   endtask

   task automatic test_gaps();
      int gaps [N];
      logic [NB-1:0] gd;
      int gc, e_last;
      logic gf;
      gaps = '{0, 2, 1, 0, 3, 0, 1, 0};
      clear_q();
      e_last = 0;
      for (int j = 0; j < N; j++) begin
         valid_in = 1'b1;
         input_data = (j < N/2) ? NB'(100 + 2*j) : NB'(100 + 2*(j-N/2) + 1);
         e_last = cyc + 1;
         tick();
         valid_in = 1'b0;
         repeat (gaps[j]) tick();
      end
      valid_in = 1'b0;
      repeat (N + 4) tick();
      chk_cnt++; if (mq_data.size() != N) $display("FAIL gaps_count got %0d want %0d", mq_data.size(), N); else pass_cnt++;
      for (int i = 0; i < N; i++) begin
         gd = (i < mq_data.size()) ? mq_data[i] : 'x;
         gc = (i < mq_cyc.size()) ? mq_cyc[i] : -1;
         gf = (i < mq_first.size()) ? mq_first[i] : 1'bx;
         chk_cnt++; if (gd !== NB'(100 + i)) $display("FAIL gaps_data[%0d] got %h want %h", i, gd, NB'(100 + i)); else pass_cnt++;
         chk_cnt++; if (gc != e_last + 1 + i) $display("FAIL gaps_cycle[%0d] got %0d want %0d", i, gc, e_last + 1 + i); else pass_cnt++;
         chk_cnt++; if (gf !== (i == 0)) $display("FAIL gaps_first[%0d] got %b want %b", i, gf, (i == 0)); else pass_cnt++;
      end
   endtask

   task automatic test_overflow();
      start = 1'b1; valid_in = 1'b0; tick();
      start = 1'b0;
      force dut.full_q = 2'b11;
      valid_in = 1'b1; input_data = 16'h0055; tick();
      valid_in = 1'b0;
      chk_cnt++; if (overflow !== 1'b1) $display("FAIL ovf_set got %b want 1", overflow); else pass_cnt++;
      chk_cnt++; if (dut.wr_cnt_q !== 3'd0) $display("FAIL ovf_cnt_hold got %0d want 0", dut.wr_cnt_q); else pass_cnt++;
      release dut.full_q;
      repeat (3) tick();
      chk_cnt++; if (overflow !== 1'b1) $display("FAIL ovf_sticky got %b want 1", overflow); else pass_cnt++;
      start = 1'b1; tick();
      start = 1'b0;
      chk_cnt++; if (overflow !== 1'b0) $display("FAIL ovf_start_clear got %b want 0", overflow); else pass_cnt++;
      chk_cnt++; if (valid_out !== 1'b0) $display("FAIL ovf_start_valid got %b want 0", valid_out); else pass_cnt++;
      repeat (N + 2) tick();
      clear_q();
   endtask

   task automatic test_start_midframe();
      frame_t nat;
      logic [NB-1:0] bsplit [N-1];
      logic [NB-1:0] gd;
      int gc, e_s;
      logic gf;
      bsplit = '{16'h0402, 16'h0404, 16'h0406, 16'h0401, 16'h0403, 16'h0405, 16'h0407};
      for (int k = 0; k < N; k++) nat[k] = NB'(200 + k);
      feed_frame(nat);
      for (int j = 0; j < 5; j++) begin
         valid_in = 1'b1; input_data = NB'(16'h0300 + j); tick();
      end
      chk_cnt++; if (valid_out !== 1'b1) $display("FAIL start_pre_drain got %b want 1", valid_out); else pass_cnt++;
      e_s = cyc + 1;
      start = 1'b1; valid_in = 1'b1; input_data = 16'h00AA; tick();
      start = 1'b0;
      chk_cnt++; if (valid_out !== 1'b0) $display("FAIL start_abandon got %b want 0", valid_out); else pass_cnt++;
      chk_cnt++; if (frame_first !== 1'b0) $display("FAIL start_first got %b want 0", frame_first); else pass_cnt++;
      clear_q();
      for (int j = 0; j < N-1; j++) begin
         valid_in = 1'b1; input_data = bsplit[j]; tick();
      end
      valid_in = 1'b0;
      repeat (N + 4) tick();
      chk_cnt++; if (mq_data.size() != N) $display("FAIL start_count got %0d want %0d", mq_data.size(), N); else pass_cnt++;
      for (int i = 0; i < N; i++) begin
         gd = (i < mq_data.size()) ? mq_data[i] : 'x;
         gc = (i < mq_cyc.size()) ? mq_cyc[i] : -1;
         gf = (i < mq_first.size()) ? mq_first[i] : 1'bx;
         chk_cnt++;
         if (gd !== ((i == 0) ? 16'h00AA : NB'(16'h0400 + i))) $display("FAIL start_data[%0d] got %h want %h", i, gd, (i == 0) ? 16'h00AA : NB'(16'h0400 + i));
         else pass_cnt++;
         chk_cnt++; if (gc != e_s + N + i) $display("FAIL start_cycle[%0d] got %0d want %0d", i, gc, e_s + N + i); else pass_cnt++;
         chk_cnt++; if (gf !== (i == 0)) $display("FAIL start_flag[%0d] got %b want %b", i, gf, (i == 0)); else pass_cnt++;
      end
   endtask

   task automatic test_reset_and_chain();
      frame_t nat;
      logic [NB-1:0] exp_q [$];
      logic [NB-1:0] gd;
      int gc, e0;
      logic gf;
      for (int k = 0; k < N; k++) nat[k] = NB'(500 + k);
      feed_frame(nat);
      valid_in = 1'b0;
      tick();
      tick();
      chk_cnt++; if (valid_out !== 1'b1) $display("FAIL rstmid_pre_drain got %b want 1", valid_out); else pass_cnt++;
      #2;
      reset_n = 1'b0;
      #1;
      chk_cnt++; if (valid_out !== 1'b0) $display("FAIL rstmid_valid got %b want 0", valid_out); else pass_cnt++;
      chk_cnt++; if (output_data !== 16'h0000) $display("FAIL rstmid_data got %h want 0000", output_data); else pass_cnt++;
      chk_cnt++; if (frame_first !== 1'b0) $display("FAIL rstmid_first got %b want 0", frame_first); else pass_cnt++;
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      clear_q();
      e0 = cyc + 1;
      for (int f = 0; f < 3; f++) begin
         for (int k = 0; k < N; k++) begin
            nat[k] = NB'($urandom_range(0, 65535));
            exp_q.push_back(nat[k]);
         end
         feed_frame(nat);
      end
      valid_in = 1'b0;
      repeat (N + 4) tick();
      chk_cnt++; if (mq_data.size() != 3*N) $display("FAIL chain_count got %0d want %0d", mq_data.size(), 3*N); else pass_cnt++;
      for (int i = 0; i < 3*N; i++) begin
         gd = (i < mq_data.size()) ? mq_data[i] : 'x;
         gc = (i < mq_cyc.size()) ? mq_cyc[i] : -1;
         gf = (i < mq_first.size()) ? mq_first[i] : 1'bx;
         chk_cnt++; if (gd !== exp_q[i]) $display("FAIL chain_data[%0d] got %h want %h", i, gd, exp_q[i]); else pass_cnt++;
         chk_cnt++; if (gc != e0 + N + i) $display("FAIL chain_cycle[%0d] got %0d want %0d", i, gc, e0 + N + i); else pass_cnt++;
         chk_cnt++; if (gf !== (i % N == 0)) $display("FAIL chain_first[%0d] got %b want %b", i, gf, (i % N == 0)); else pass_cnt++;
      end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_gaps();
      test_overflow();
      test_start_midframe();
      test_reset_and_chain();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
